hb_decim2_out: RTL and testbench

- Downstream neighbour of hb_filter. Takes the filter's full-rate 16-bit signed output and decimates it by 2, keeping one of every two valid samples.
- Kept samples are buffered in a small FIFO and presented to the consumer over a valid/ready handshake.
- Flags any kept sample that is lost because the buffer is full.

---
 rtl/hb_pkg.sv | 21 ++
 rtl/hb_sample_fifo.sv | 101 ++++++++++
 rtl/hb_decim2_out.sv | 124 ++++++++++++
 tb/tb_hb_decim2_out.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hb_pkg.sv
// rtl/hb_pkg.sv - shared types and constants for the half-band decimate-by-2 output stage
//
// Contents:
//   HB_DECIM      decimation ratio of the output stage
//   HB_W          native sample width of hb_filter y_out
//   sample_t      signed sample type at the native width
//   hb_level_w()  width needed to hold a FIFO occupancy of 0..depth

package hb_pkg;

    localparam int HB_DECIM = 2;
    localparam int HB_W     = 16;

    typedef logic signed [HB_W-1:0] sample_t;

    // Occupancy counts run 0..depth inclusive, so one bit more than the pointer.
    function automatic int hb_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hb_sample_fifo.sv
// rtl/hb_sample_fifo.sv - first-word-fall-through sample FIFO with flush and occupancy
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   i_flush   in   synchronous empty; wins over push and pop
//   i_push    in   write request; accepted when not full or when a pop happens this cycle
//   i_wdata   in   W-bit write data
//   i_pop     in   read request; ignored when empty
//   o_rdata   out  head sample; holds the last head once the FIFO drains
//   o_empty   out  FIFO holds no samples
//   o_full    out  FIFO holds DEPTH samples
//   o_level   out  current occupancy, 0..DEPTH

module hb_sample_fifo
    import hb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = HB_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_last;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept a push when it is also being read.
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

    // Storage carries no reset: a slot is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                // Power-of-two depth lets the pointers wrap by natural overflow.
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end
            // Remember the presented head so the output does not fall back to
            // stale storage when the FIFO drains.
            if (!w_empty) begin
                r_last <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_rdata = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule

// File: rtl/hb_decim2_out.sv
// rtl/hb_decim2_out.sv - decimate-by-2 output stage for hb_filter with buffered valid/ready output
//
// Keeps one of every two valid input samples, buffers the kept samples and
// presents them over a valid/ready handshake. A sticky flag records any kept
// sample lost because the buffer was full.
//
// Build option: define HB_DECIM2_STATS_EN to add the drop_cnt output.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   flush        in   synchronous: empty buffer, restart phase; overrun kept
//   x_valid      in   qualifies x_in
//   x_in         in   signed W-bit sample from hb_filter
//   y_valid      out  buffer head valid
//   y_ready      in   consumer accepts head when y_valid && y_ready
//   y_out        out  signed head sample, stable while stalled
//   overrun      out  sticky: a kept sample was dropped
//   overrun_clr  in   synchronous clear of overrun (a new drop wins)
//   level        out  buffer occupancy
//   drop_cnt     out  saturating count of dropped samples (HB_DECIM2_STATS_EN only)

module hb_decim2_out
    import hb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int KEEP_PHASE = 0,
    parameter int W          = HB_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       x_valid,
    input  logic signed [W-1:0]        x_in,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic signed [W-1:0]        y_out,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic [$clog2(DEPTH):0]     level
`ifdef HB_DECIM2_STATS_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int PW = $clog2(HB_DECIM);
    localparam logic [PW-1:0] KEEP_SEL = PW'(KEEP_PHASE);

    logic [PW-1:0] r_phase;
    logic          r_overrun;

    logic          w_keep;
    logic          w_drop;
    logic          w_empty;
    logic          w_full;
    logic [W-1:0]  w_head;

    assign w_keep = x_valid && (r_phase == KEEP_SEL);

    // A drop needs a full buffer with no simultaneous pop. Full implies
    // non-empty, so y_ready alone decides whether the head leaves. A sample
    // discarded by flush is not an overrun.
    assign w_drop = w_keep && w_full && !y_ready && !flush;

    // Phase advances only on valid input so gaps do not shift the keep pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (flush) begin
            r_phase <= '0;
        end else if (x_valid) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // Set wins over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef HB_DECIM2_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (overrun_clr) begin
            r_drop_cnt <= {15'd0, w_drop};
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    hb_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_push  (w_keep),
        .i_wdata (x_in),
        .i_pop   (y_ready),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (level)
    );

    assign y_valid = !w_empty;
    assign y_out   = w_head;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_hb_decim2_out.sv
// tb/tb_hb_decim2_out.sv - directed self-checking bench for hb_decim2_out (both keep phases)

module tb_hb_decim2_out;
    import hb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          x_valid;
    sample_t       x_in;
    logic          y_ready;
    logic          overrun_clr;

    logic          y_valid0, y_valid1;
    sample_t       y_out0, y_out1;
    logic          overrun0, overrun1;
    logic [LW-1:0] level0, level1;
`ifdef HB_DECIM2_STATS_EN
    logic [15:0]   drop_cnt0, drop_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int gv  [6] = '{1, 0, 1, 1, 0, 1};
    int gx  [6] = '{10, 99, 11, 12, 99, 13};
    int e0v [6] = '{1, 0, 0, 1, 0, 0};
    int e0y [6] = '{10, 10, 10, 12, 12, 12};
    int e1v [6] = '{0, 0, 1, 0, 0, 1};
    int e1y [6] = '{15, 15, 11, 11, 11, 13};

    always #5 clk = ~clk;

    hb_decim2_out #(.DEPTH(DEPTH), .KEEP_PHASE(0), .W(16)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .x_valid     (x_valid),
        .x_in        (x_in),
        .y_valid     (y_valid0),
        .y_ready     (y_ready),
        .y_out       (y_out0),
        .overrun     (overrun0),
        .overrun_clr (overrun_clr),
        .level       (level0)
`ifdef HB_DECIM2_STATS_EN
        ,
        .drop_cnt    (drop_cnt0)
`endif
    );

    hb_decim2_out #(.DEPTH(DEPTH), .KEEP_PHASE(1), .W(16)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .x_valid     (x_valid),
        .x_in        (x_in),
        .y_valid     (y_valid1),
        .y_ready     (y_ready),
        .y_out       (y_out1),
        .overrun     (overrun1),
        .overrun_clr (overrun_clr),
        .level       (level1)
`ifdef HB_DECIM2_STATS_EN
        ,
        .drop_cnt    (drop_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int x);
        x_valid = v;
        x_in    = sample_t'(x);
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        x_valid     = 1'b0;
        x_in        = '0;
        y_ready     = 1'b0;
        overrun_clr = 1'b0;
        #1;
        chk("rst_valid0", 32'(y_valid0), 0);
        chk("rst_yout0",  32'(y_out0),   0);
        chk("rst_ovr0",   32'(overrun0), 0);
        chk("rst_level0", 32'(level0),   0);
        chk("rst_level1", 32'(level1),   0);
        tick();
        tick();
        reset = 1'b0;

        // Ramp 0..15 with the consumer always ready.
        y_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i);
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("ramp%0d_v0", i), 32'(y_valid0), 1);
                chk($sformatf("ramp%0d_y0", i), 32'(y_out0),   i);
                chk($sformatf("ramp%0d_v1", i), 32'(y_valid1), 0);
                chk($sformatf("ramp%0d_y1", i), 32'(y_out1),   (i == 0) ? 0 : i - 1);
            end else begin
                chk($sformatf("ramp%0d_v0", i), 32'(y_valid0), 0);
                chk($sformatf("ramp%0d_y0", i), 32'(y_out0),   i - 1);
                chk($sformatf("ramp%0d_v1", i), 32'(y_valid1), 1);
                chk($sformatf("ramp%0d_y1", i), 32'(y_out1),   i);
            end
            chk($sformatf("ramp%0d_ovr", i), 32'(overrun0 | overrun1), 0);
        end

        // Gapped input: phase only moves on valid cycles.
        for (int i = 0; i < 6; i++) begin
            drive(gv[i] != 0, gx[i]);
            tick();
            chk($sformatf("gap%0d_v0", i),   32'(y_valid0), e0v[i]);
            chk($sformatf("gap%0d_y0", i),   32'(y_out0),   e0y[i]);
            chk($sformatf("gap%0d_lvl0", i), 32'(level0),   e0v[i]);
            chk($sformatf("gap%0d_v1", i),   32'(y_valid1), e1v[i]);
            chk($sformatf("gap%0d_y1", i),   32'(y_out1),   e1y[i]);
        end

        // Backpressure: fill, then overflow.
        y_ready = 1'b0;
        flush   = 1'b1;
        drive(1'b0, 0);
        tick();
        flush = 1'b0;
        chk("pre_bp_level1", 32'(level1),   0);
        chk("pre_bp_valid1", 32'(y_valid1), 0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, i);
            tick();
            chk($sformatf("bp%0d_lvl0", i), 32'(level0), (i / 2 + 1 > 4) ? 4 : i / 2 + 1);
            chk($sformatf("bp%0d_lvl1", i), 32'(level1), ((i + 1) / 2 > 4) ? 4 : (i + 1) / 2);
            chk($sformatf("bp%0d_ovr0", i), 32'(overrun0), int'(i >= 8));
            chk($sformatf("bp%0d_ovr1", i), 32'(overrun1), int'(i >= 9));
            chk($sformatf("bp%0d_head0", i), 32'(y_out0), 0);
        end
`ifdef HB_DECIM2_STATS_EN
        chk("bp_dropcnt0", 32'(drop_cnt0), 2);
        chk("bp_dropcnt1", 32'(drop_cnt1), 2);
`endif

        // Clear in the same cycle as a new drop: set wins on dut0 only.
        overrun_clr = 1'b1;
        drive(1'b1, 12);
        tick();
        overrun_clr = 1'b0;
        chk("clrdrop_ovr0", 32'(overrun0), 1);
        chk("clrdrop_ovr1", 32'(overrun1), 0);
        chk("clrdrop_lvl0", 32'(level0),   4);
`ifdef HB_DECIM2_STATS_EN
        chk("clrdrop_cnt0", 32'(drop_cnt0), 1);
        chk("clrdrop_cnt1", 32'(drop_cnt1), 0);
`endif

        // Drain in order.
        drive(1'b0, 0);
        y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_v0", k), 32'(y_valid0), 1);
            chk($sformatf("drain%0d_y0", k), 32'(y_out0),   2 * k);
            chk($sformatf("drain%0d_y1", k), 32'(y_out1),   2 * k + 1);
            tick();
        end
        chk("drain_end_v0",  32'(y_valid0), 0);
        chk("drain_end_lvl", 32'(level0),   0);

        // Flush restores phase and leaves overrun alone; then clear it.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_keeps_ovr0", 32'(overrun0), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("clr_ovr0", 32'(overrun0), 0);
`ifdef HB_DECIM2_STATS_EN
        chk("clr_cnt0", 32'(drop_cnt0), 0);
`endif

        // Full with simultaneous pop.
        y_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 20 + i);
            tick();
        end
        chk("fullpop_pre_lvl0", 32'(level0), 4);
        chk("fullpop_pre_lvl1", 32'(level1), 4);
        y_ready = 1'b1;
        drive(1'b1, 28);
        tick();
        chk("fullpop_lvl0", 32'(level0),   4);
        chk("fullpop_lvl1", 32'(level1),   3);
        chk("fullpop_ovr0", 32'(overrun0), 0);
        chk("fullpop_y1",   32'(y_out1),   23);
        drive(1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fullpop_out%0d", k), 32'(y_out0), 22 + 2 * k);
            tick();
        end
        chk("fullpop_end_v0", 32'(y_valid0), 0);
        chk("fullpop_ovr",    32'(overrun0 | overrun1), 0);

        // Flush with level 3 (phase is 1 here, so dut0 keeps the odd values).
        y_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 40 + i);
            tick();
        end
        chk("preflush_lvl0", 32'(level0), 3);
        chk("preflush_y0",   32'(y_out0), 41);
        flush = 1'b1;
        drive(1'b1, 46);
        tick();
        flush = 1'b0;
        chk("flush_lvl0", 32'(level0),   0);
        chk("flush_lvl1", 32'(level1),   0);
        chk("flush_v0",   32'(y_valid0), 0);
        chk("flush_v1",   32'(y_valid1), 0);
        drive(1'b1, 50);
        tick();
        chk("postflush_v0",   32'(y_valid0), 1);
        chk("postflush_y0",   32'(y_out0),   50);
        chk("postflush_lvl0", 32'(level0),   1);
        chk("postflush_lvl1", 32'(level1),   0);

        // Asynchronous reset mid-stream takes effect without a clock edge.
        drive(1'b1, 51);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_v0",   32'(y_valid0), 0);
        chk("midrst_y0",   32'(y_out0),   0);
        chk("midrst_lvl0", 32'(level0),   0);
        chk("midrst_ovr",  32'(overrun0 | overrun1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
